// File: rtl/uart_io_if.sv
// rtl/uart_io_if.sv - CPU I/O strobes, register offset, chip select and interrupt for uart_io
interface uart_io_if;
   logic [1:0] addr;
   logic       readio;
   logic       writeio;
   logic       select;
   logic       intr;

   modport master (output addr, readio, writeio, select, input intr);
   modport slave  (input addr, readio, writeio, select, output intr);
endinterface

// File: rtl/uart_io.sv
// rtl/uart_io.sv - I/O-mapped 8N1 serial port: holding/receive/status/control registers and intr
module uart_io #(
   parameter int unsigned DIVISOR = 16  // clocks per serial bit, 4..65535
) (
   input  logic       clock_i,
   input  logic       reset_i,
   uart_io_if.slave   bus,
   inout  wire  [7:0] data_io,
   input  logic       rxd_i,
   output logic       txd_o
);
   localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
   localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

   tx_state_e   tx_state_q, tx_state_d;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] tcnt_q, tcnt_d, rcnt_q, rcnt_d;
   logic [2:0]  tbit_q, tbit_d, rbit_q, rbit_d;
   logic [7:0]  thr_q, thr_d, tsh_q, tsh_d, rsh_q, rsh_d, rbr_q, rbr_d;
   logic        txempty_q, txempty_d, txd_q, txd_d;
   logic        rxrdy_q, rxrdy_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic        rdone_q, rdone_d, rok_q, rok_d;
   logic        rxie_q, rxie_d, txie_q, txie_d, intr_q, intr_d;
   logic        rx_meta_q, rxs_q, rxs_prev_q;
   logic        wacc_q, racc_q;
   logic [1:0]  raddr_q;
   logic        wacc, racc, wr_ev, rd_ev, rd_clr, tbit_end, txidle;
   logic [7:0]  wdata, rdata;

   // Strobes act on their leading (write) or trailing (read) edge, so long CPU cycles act once
   assign wacc     = bus.writeio & bus.select;
   assign racc     = bus.readio & bus.select;
   assign wr_ev    = wacc & ~wacc_q;
   assign rd_ev    = ~racc & racc_q;
   assign rd_clr   = rd_ev && (raddr_q == 2'd0);
   assign wdata    = data_io;
   assign tbit_end = (tcnt_q == BIT_LAST);
   assign txidle   = (tx_state_q == T_IDLE) & txempty_q;

   always_comb begin
      rdata = 8'h00;
      case (bus.addr)
         2'd0:    rdata = rbr_q;
         2'd1:    rdata = {3'b000, ferr_q, ovr_q, txidle, txempty_q, rxrdy_q};
         2'd2:    rdata = {6'b000000, txie_q, rxie_q};
         default: rdata = 8'h00;
      endcase
   end

   assign data_io = racc ? rdata : 8'bz;
   assign txd_o   = txd_q;
   assign bus.intr = intr_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tcnt_d     = tcnt_q;
      tbit_d     = tbit_q;
      tsh_d      = tsh_q;
      thr_d      = thr_q;
      txempty_d  = txempty_q;
      if (wr_ev && (bus.addr == 2'd0) && txempty_q) begin
         thr_d     = wdata;
         txempty_d = 1'b0;
      end
      case (tx_state_q)
         T_IDLE: begin
            tcnt_d = '0;
            if (!txempty_q) begin
               tsh_d      = thr_q;
               txempty_d  = 1'b1;
               tx_state_d = T_START;
            end
         end
         T_START: begin
            tcnt_d = tbit_end ? '0 : tcnt_q + 16'd1;
            if (tbit_end) begin
               tbit_d     = '0;
               tx_state_d = T_DATA;
            end
         end
         T_DATA: begin
            tcnt_d = tbit_end ? '0 : tcnt_q + 16'd1;
            if (tbit_end) begin
               tsh_d  = {1'b0, tsh_q[7:1]};
               tbit_d = tbit_q + 3'd1;
               if (tbit_q == 3'd7) tx_state_d = T_STOP;
            end
         end
         default: begin
            tcnt_d = tbit_end ? '0 : tcnt_q + 16'd1;
            // A preloaded holding register chains straight into the next start bit
            if (tbit_end) begin
               if (!txempty_q) begin
                  tsh_d      = thr_q;
                  txempty_d  = 1'b1;
                  tx_state_d = T_START;
               end else begin
                  tx_state_d = T_IDLE;
               end
            end
         end
      endcase
      case (tx_state_q)
         T_START: txd_d = 1'b0;
         T_DATA:  txd_d = tsh_q[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rcnt_d     = rcnt_q;
      rbit_d     = rbit_q;
      rsh_d      = rsh_q;
      rdone_d    = 1'b0;
      rok_d      = rok_q;
      case (rx_state_q)
         R_IDLE: begin
            rcnt_d = '0;
            if (rxs_prev_q && !rxs_q) rx_state_d = R_START;
         end
         R_START: begin
            if (rcnt_q == HALF_LAST) begin
               rcnt_d     = '0;
               rbit_d     = '0;
               rx_state_d = rxs_q ? R_IDLE : R_DATA;
            end else begin
               rcnt_d = rcnt_q + 16'd1;
            end
         end
         R_DATA: begin
            if (rcnt_q == BIT_LAST) begin
               rcnt_d = '0;
               rsh_d  = {rxs_q, rsh_q[7:1]};
               rbit_d = rbit_q + 3'd1;
               if (rbit_q == 3'd7) rx_state_d = R_STOP;
            end else begin
               rcnt_d = rcnt_q + 16'd1;
            end
         end
         default: begin
            if (rcnt_q == BIT_LAST) begin
               rcnt_d     = '0;
               rdone_d    = 1'b1;
               rok_d      = rxs_q;
               rx_state_d = R_IDLE;
            end else begin
               rcnt_d = rcnt_q + 16'd1;
            end
         end
      endcase
   end

   always_comb begin
      rxrdy_d = rxrdy_q;
      rbr_d   = rbr_q;
      ovr_d   = ovr_q;
      ferr_d  = ferr_q;
      rxie_d  = rxie_q;
      txie_d  = txie_q;
      if (wr_ev && (bus.addr == 2'd1)) begin
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end
      if (wr_ev && (bus.addr == 2'd2)) begin
         rxie_d = wdata[0];
         txie_d = wdata[1];
      end
      if (rd_clr) rxrdy_d = 1'b0;
      // A read clearing rxrdy on the completion clock frees the slot for the new byte
      if (rdone_q) begin
         if (!rok_q) begin
            ferr_d = 1'b1;
         end else if (!rxrdy_q || rd_clr) begin
            rbr_d   = rsh_q;
            rxrdy_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
      intr_d = (rxie_q & rxrdy_q) | (txie_q & txempty_q);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         tx_state_q <= T_IDLE;
         rx_state_q <= R_IDLE;
         tcnt_q     <= '0;
         rcnt_q     <= '0;
         tbit_q     <= '0;
         rbit_q     <= '0;
         thr_q      <= '0;
         tsh_q      <= '0;
         rsh_q      <= '0;
         rbr_q      <= '0;
         txempty_q  <= 1'b1;
         txd_q      <= 1'b1;
         rxrdy_q    <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         rdone_q    <= 1'b0;
         rok_q      <= 1'b0;
         rxie_q     <= 1'b0;
         txie_q     <= 1'b0;
         intr_q     <= 1'b0;
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         wacc_q     <= 1'b0;
         racc_q     <= 1'b0;
         raddr_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tcnt_q     <= tcnt_d;
         rcnt_q     <= rcnt_d;
         tbit_q     <= tbit_d;
         rbit_q     <= rbit_d;
         thr_q      <= thr_d;
         tsh_q      <= tsh_d;
         rsh_q      <= rsh_d;
         rbr_q      <= rbr_d;
         txempty_q  <= txempty_d;
         txd_q      <= txd_d;
         rxrdy_q    <= rxrdy_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         rdone_q    <= rdone_d;
         rok_q      <= rok_d;
         rxie_q     <= rxie_d;
         txie_q     <= txie_d;
         intr_q     <= intr_d;
         rx_meta_q  <= rxd_i;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
         wacc_q     <= wacc;
         racc_q     <= racc;
         if (racc) raddr_q <= bus.addr;
      end
   end
endmodule

// File: tb/tb_uart_io.sv
// tb/tb_uart_io.sv - table-driven and scoreboard bench for uart_io
module tb_uart_io;
   localparam int DIV = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       txd;
   logic [7:0] tb_wdata = 8'h00;
   logic       tb_wen = 1'b0;
   wire  [7:0] data;

   int         total = 0;
   int         bad = 0;
   logic       mon_en = 1'b1;
   logic [7:0] mon_b;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   time        start_t[$];
   time        wr_edge_t;

   typedef struct { logic [1:0] addr; logic [7:0] exp; } rd_vec_t;
   typedef struct { logic [7:0] wval; logic [7:0] rexp; logic iexp; } ctl_vec_t;
   rd_vec_t  rv[4];
   ctl_vec_t cv[4];

   assign data = tb_wen ? tb_wdata : 8'bz;

   uart_io_if bus();

   uart_io #(.DIVISOR(DIV)) dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus     (bus),
      .data_io (data),
      .rxd_i   (rxd),
      .txd_o   (txd)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h req=%0h", name, got, exp);
      end
   endtask

   // Callers sit on a negedge; each access ends with one idle cycle so strobes never merge
   task automatic cpu_write(input logic [1:0] a, input logic [7:0] v);
      bus.addr = a; tb_wdata = v; tb_wen = 1'b1;
      bus.writeio = 1'b1; bus.select = 1'b1;
      @(posedge clock);
      wr_edge_t = $time;
      @(negedge clock);
      bus.writeio = 1'b0; bus.select = 1'b0; tb_wen = 1'b0;
      @(negedge clock);
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [7:0] v);
      bus.addr = a; bus.readio = 1'b1; bus.select = 1'b1;
      #1 v = data;
      @(negedge clock);
      bus.readio = 1'b0; bus.select = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (DIV) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge clock);
      end
      rxd = stop;
      repeat (DIV) @(negedge clock);
      rxd = 1'b1;
   endtask

   task automatic wait_rxrdy(output logic [7:0] s);
      s = 8'h00;
      for (int i = 0; i < 40; i++) begin
         cpu_read(2'd1, s);
         if (s[0]) break;
      end
      check("rx_rdy_wait", s[0], 1);
   endtask

   initial begin : tx_monitor
      forever begin
         @(negedge clock);
         if (mon_en && !reset && txd === 1'b0) begin
            start_t.push_back($time);
            repeat (DIV / 2) @(negedge clock);
            check("tx_start_bit", txd, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clock);
               mon_b[i] = txd;
            end
            repeat (DIV) @(negedge clock);
            check("tx_stop_bit", txd, 1);
            if (tx_q.size() == 0) begin
               total++; bad++;
               $display("FAIL tx_unexpected_frame got=%0h req=none", mon_b);
            end else begin
               check("tx_byte", mon_b, tx_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog got=timeout req=finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0] s, d;
      int n;
      longint gap;
      bus.addr = 2'd0; bus.readio = 1'b0; bus.writeio = 1'b0; bus.select = 1'b0;

      rv[0] = '{2'd0, 8'h00};
      rv[1] = '{2'd1, 8'h06};
      rv[2] = '{2'd2, 8'h00};
      rv[3] = '{2'd3, 8'h00};
      cv[0] = '{8'h03, 8'h03, 1'b1};
      cv[1] = '{8'hFE, 8'h02, 1'b1};
      cv[2] = '{8'h01, 8'h01, 1'b0};
      cv[3] = '{8'h00, 8'h00, 1'b0};

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_txd", txd, 1);
      check("reset_intr", bus.intr, 0);
      for (int i = 0; i < 4; i++) begin
         cpu_read(rv[i].addr, s);
         check($sformatf("reset_reg%0d", i), s, rv[i].exp);
      end
      cpu_write(2'd3, 8'hFF);
      cpu_read(2'd3, s);
      check("reg3_ignores_write", s, 8'h00);

      for (int i = 0; i < 4; i++) begin
         cpu_write(2'd2, cv[i].wval);
         @(negedge clock);
         check($sformatf("ctrl_intr%0d", i), bus.intr, cv[i].iexp);
         cpu_read(2'd2, s);
         check($sformatf("ctrl_read%0d", i), s, cv[i].rexp);
      end

      // Single frame: latency, start-bit width and txidle edge
      tx_q.push_back(8'hA5);
      cpu_write(2'd0, 8'hA5);
      n = 0;
      while (txd !== 1'b0 && n < 10) begin @(negedge clock); n++; end
      check("tx_start_latency", ($time - wr_edge_t) / 10, 2);
      n = 0;
      while (txd === 1'b0 && n < 40) begin @(negedge clock); n++; end
      check("tx_start_width", n, DIV);
      repeat (142) @(negedge clock);
      cpu_read(2'd1, s);
      check("tx_busy_before_160", s, 8'h02);
      cpu_read(2'd1, s);
      check("tx_idle_after_160", s, 8'h06);

      // Back-to-back: second byte preloaded, third discarded while holding register is full
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      cpu_write(2'd0, 8'h11);
      cpu_write(2'd0, 8'h22);
      cpu_read(2'd1, s);
      check("tx_thr_full_status", s, 8'h00);
      cpu_write(2'd0, 8'h33);
      repeat (400) @(negedge clock);
      check("tx_frame_count", start_t.size(), 3);
      gap = (start_t.size() >= 2) ? (start_t[$] - start_t[$-1]) / 10 : -1;
      check("tx_no_gap", gap, 10 * DIV);
      check("tx_queue_drained", tx_q.size(), 0);
      cpu_read(2'd1, s);
      check("tx_idle_after_b2b", s, 8'h06);

      rx_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_rxrdy(s);
      check("rx_status_ready", s, 8'h07);
      cpu_read(2'd0, d);
      check("rx_data_3c", d, rx_q.pop_front());
      cpu_read(2'd1, s);
      check("rx_rdy_cleared", s, 8'h06);

      rx_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      send_frame(8'hC3, 1'b1);
      repeat (10) @(negedge clock);
      cpu_read(2'd1, s);
      check("rx_overrun_status", s, 8'h0F);
      cpu_write(2'd1, 8'h00);
      cpu_read(2'd1, s);
      check("rx_overrun_cleared", s, 8'h07);
      cpu_read(2'd0, d);
      check("rx_overrun_keeps_first", d, rx_q.pop_front());
      cpu_read(2'd1, s);
      check("rx_after_overrun_read", s, 8'h06);

      send_frame(8'h77, 1'b0);
      repeat (10) @(negedge clock);
      cpu_read(2'd1, s);
      check("rx_framing_status", s, 8'h16);
      cpu_write(2'd1, 8'hFF);
      cpu_read(2'd1, s);
      check("rx_framing_cleared", s, 8'h06);

      rxd = 1'b0;
      repeat (4) @(negedge clock);
      rxd = 1'b1;
      repeat (200) @(negedge clock);
      cpu_read(2'd1, s);
      check("rx_false_start", s, 8'h06);

      cpu_write(2'd2, 8'h01);
      @(negedge clock);
      check("intr_rxie_idle", bus.intr, 0);
      rx_q.push_back(8'h96);
      send_frame(8'h96, 1'b1);
      wait_rxrdy(s);
      @(negedge clock);
      check("intr_on_rx", bus.intr, 1);
      cpu_read(2'd0, d);
      check("rx_data_96", d, rx_q.pop_front());
      @(negedge clock);
      check("intr_cleared_by_read", bus.intr, 0);
      cpu_write(2'd2, 8'h00);

      // Reset in mid-frame on both directions
      mon_en = 1'b0;
      cpu_write(2'd0, 8'h00);
      rxd = 1'b0;
      repeat (40) @(negedge clock);
      check("tx_mid_frame_low", txd, 0);
      #2 reset = 1'b1;
      #1 check("reset_async_txd", txd, 1);
      @(negedge clock);
      reset = 1'b0;
      rxd = 1'b1;
      repeat (200) @(negedge clock);
      cpu_read(2'd1, s);
      check("reset_mid_frame_status", s, 8'h06);
      cpu_read(2'd0, d);
      check("reset_mid_frame_rbr", d, 8'h00);
      check("reset_txd_idle", txd, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
